// File: rtl/alut_lookup_engine_if.sv
// Signal bundle around the ALUT lookup engine: switch-side request/result,
// the address-check memory port and the age-checker handshake.
interface alut_lookup_engine_if;
  logic        lookup_req;
  logic [47:0] lookup_addr;
  logic [1:0]  lookup_port;
  logic [31:0] curr_time;
  logic [82:0] mem_read_data;
  logic        age_check_active;
  logic        age_confirmed;
  logic        age_ok;

  logic [7:0]  mem_addr;
  logic        mem_write;
  logic [82:0] mem_write_data;
  logic        check_age;
  logic [31:0] last_accessed;
  logic        add_check_active;
  logic        lookup_ack;
  logic        lookup_hit;
  logic        lookup_aged;
  logic        lookup_err;
  logic [1:0]  lookup_dst_port;

  // Engine side
  modport slave (
    input  lookup_req, lookup_addr, lookup_port, curr_time, mem_read_data,
           age_check_active, age_confirmed, age_ok,
    output mem_addr, mem_write, mem_write_data, check_age, last_accessed,
           add_check_active, lookup_ack, lookup_hit, lookup_aged, lookup_err,
           lookup_dst_port
  );

  // Surrounding logic (switch, memory, age checker)
  modport master (
    output lookup_req, lookup_addr, lookup_port, curr_time, mem_read_data,
           age_check_active, age_confirmed, age_ok,
    input  mem_addr, mem_write, mem_write_data, check_age, last_accessed,
           add_check_active, lookup_ack, lookup_hit, lookup_aged, lookup_err,
           lookup_dst_port
  );
endinterface

// File: rtl/alut_lookup_engine.sv
// ALUT address-lookup initiator: hashes a MAC to a table index, reads the entry,
// arbitrates an age check on a tag hit, then refreshes, relearns or flags a timeout.
//   state | meaning
//   IDLE  | waiting for lookup_req
//   RD    | index presented to the memory
//   CMP   | read data valid, tag compare
//   ARB   | tag hit, waiting for the age checker to go idle
//   REQ   | check_age pulse, age checker claimed
//   WAIT  | waiting for age_confirmed or timeout
//   WR    | entry write
//   DONE  | lookup_ack pulse
module alut_lookup_engine #(
  parameter int unsigned AGE_TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                p_reset,
  alut_lookup_engine_if.slave lk
);

  localparam int unsigned CNT_W = $clog2(AGE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CMP,
    S_ARB,
    S_REQ,
    S_WAIT,
    S_WR,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [47:0]      addr_q, addr_d;
  logic [1:0]       port_q, port_d;
  logic [7:0]       idx_q, idx_d;
  logic [1:0]       sport_q, sport_d;
  logic [31:0]      last_q, last_d;
  logic [82:0]      wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic             aged_q, aged_d;
  logic             err_q, err_d;
  logic [1:0]       dst_q, dst_d;

  logic [7:0]       idx_in;
  logic             tag_match;
  logic [82:0]      learn_data;

  assign idx_in = lk.lookup_addr[47:40] ^ lk.lookup_addr[39:32] ^ lk.lookup_addr[31:24]
                ^ lk.lookup_addr[23:16] ^ lk.lookup_addr[15:8]  ^ lk.lookup_addr[7:0];

  assign tag_match  = lk.mem_read_data[82] && (lk.mem_read_data[47:0] == addr_q);

  // Learn and refresh writes share one format; curr_time is taken when the data is selected.
  assign learn_data = {1'b1, lk.curr_time, port_q, addr_q};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    port_d   = port_q;
    idx_d    = idx_q;
    sport_d  = sport_q;
    last_d   = last_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    hit_d    = hit_q;
    aged_d   = aged_q;
    err_d    = err_q;
    dst_d    = dst_q;

    lk.mem_addr         = '0;
    lk.mem_write        = 1'b0;
    lk.mem_write_data   = '0;
    lk.check_age        = 1'b0;
    lk.add_check_active = 1'b0;
    lk.lookup_ack       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (lk.lookup_req) begin
          addr_d  = lk.lookup_addr;
          port_d  = lk.lookup_port;
          idx_d   = idx_in;
          hit_d   = 1'b0;
          aged_d  = 1'b0;
          err_d   = 1'b0;
          dst_d   = '0;
          state_d = S_RD;
        end
      end

      S_RD: begin
        lk.mem_addr = idx_q;
        state_d     = S_CMP;
      end

      S_CMP: begin
        if (tag_match) begin
          last_d  = lk.mem_read_data[81:50];
          sport_d = lk.mem_read_data[49:48];
          state_d = S_ARB;
        end else begin
          wdata_d = learn_data;
          state_d = S_WR;
        end
      end

      S_ARB: begin
        if (!lk.age_check_active) begin
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        lk.check_age        = 1'b1;
        lk.add_check_active = 1'b1;
        cnt_d               = '0;
        state_d             = S_WAIT;
      end

      S_WAIT: begin
        lk.add_check_active = 1'b1;
        cnt_d               = cnt_q + CNT_W'(1);
        // A confirm in the last counted cycle still wins over the timeout.
        if (lk.age_confirmed) begin
          wdata_d = learn_data;
          if (lk.age_ok) begin
            hit_d = 1'b1;
            dst_d = sport_q;
          end else begin
            aged_d = 1'b1;
          end
          state_d = S_WR;
        end else if (cnt_q == CNT_W'(AGE_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_WR: begin
        lk.mem_write      = 1'b1;
        lk.mem_addr       = idx_q;
        lk.mem_write_data = wdata_q;
        state_d           = S_DONE;
      end

      S_DONE: begin
        lk.lookup_ack = 1'b1;
        state_d       = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge p_reset) begin
    if (p_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      port_q  <= '0;
      idx_q   <= '0;
      sport_q <= '0;
      last_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      aged_q  <= 1'b0;
      err_q   <= 1'b0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      port_q  <= port_d;
      idx_q   <= idx_d;
      sport_q <= sport_d;
      last_q  <= last_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      aged_q  <= aged_d;
      err_q   <= err_d;
      dst_q   <= dst_d;
    end
  end

  assign lk.last_accessed   = last_q;
  assign lk.lookup_hit      = hit_q;
  assign lk.lookup_aged     = aged_q;
  assign lk.lookup_err      = err_q;
  assign lk.lookup_dst_port = dst_q;

endmodule

// File: tb/tb_alut_lookup_engine.sv
// Bench for alut_lookup_engine: table and age checker modelled per transaction,
// expectations computed from the lookup rules (hash, tag hit, latency formulas).
module tb_alut_lookup_engine;

  localparam int unsigned AGE_TIMEOUT = 16;

  logic pclk = 1'b0;
  logic p_reset;
  always #5 pclk = ~pclk;

  alut_lookup_engine_if lk();

  alut_lookup_engine #(.AGE_TIMEOUT(AGE_TIMEOUT)) dut (
    .pclk    (pclk),
    .p_reset (p_reset),
    .lk      (lk)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [82:0] phys_mem [256];
  logic [82:0] ref_mem  [256];
  logic [31:0] ct       [64];
  int          obs_ack;
  logic [7:0]  obs_wr_a;

  task automatic check_val(input string tag, input logic [82:0] obs, input logic [82:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hash(input logic [47:0] a);
    logic [7:0] h;
    h = '0;
    for (int i = 0; i < 6; i++) h ^= a[8*i +: 8];
    return h;
  endfunction

  function automatic logic [82:0] outs_vec();
    return 83'({lk.mem_write, lk.check_age, lk.add_check_active, lk.lookup_ack,
                lk.lookup_hit, lk.lookup_aged, lk.lookup_err, lk.lookup_dst_port,
                lk.mem_addr, lk.last_accessed});
  endfunction

  // dly = cycles from check_age to age_confirmed; 0 means the checker never answers.
  // busy = number of cycles after accept that age_check_active is held high.
  task automatic run_lookup(input logic [47:0] addr, input logic [1:0] port, input int busy,
                            input int dly, input bit ok, input bit keep_req, input int abort_at);
    logic [7:0]  idx;
    logic [82:0] ent;
    bit          tag;
    logic [7:0]  rd_a;
    logic [7:0]  wr_a;
    logic [82:0] wr_d;
    logic [82:0] exp_wd;
    int ack_c, wr_c, wr_n, ca_c, ca_n, aca_n, aca_first, bad_wd;
    int req_c, exp_ack, exp_wr, exp_aca;
    bit exp_hit, exp_aged, exp_err;
    logic [1:0]  exp_dst;
    logic        seen_hit, seen_aged, seen_err;
    logic [1:0]  seen_dst;
    logic [31:0] seen_last;

    idx = hash(addr);
    ent = ref_mem[idx];
    tag = ent[82] && (ent[47:0] == addr);
    rd_a = '0; wr_a = '0; wr_d = '0; exp_wd = '0;
    ack_c = -1; wr_c = -1; wr_n = 0; ca_c = -1; ca_n = 0; aca_n = 0; aca_first = -1; bad_wd = 0;
    seen_hit = 1'b0; seen_aged = 1'b0; seen_err = 1'b0; seen_dst = '0; seen_last = '0;

    @(negedge pclk);
    lk.lookup_req  = 1'b1;
    lk.lookup_addr = addr;
    lk.lookup_port = port;
    lk.age_check_active = 1'b0;
    lk.age_confirmed    = 1'b0;

    for (int n = 1; n <= 60 && ack_c < 0; n++) begin
      @(negedge pclk);
      if (n == abort_at) begin
        p_reset = 1'b1;
        lk.lookup_req = 1'b0;
        lk.age_confirmed = 1'b0;
        @(posedge pclk);
        #1;
        check_val("rst_outs", outs_vec(), '0);
        check_val("rst_wdata", lk.mem_write_data, '0);
        check_val("abort_nowr", 83'(wr_n), '0);
        for (int k = 0; k < 3; k++) begin
          @(negedge pclk);
          if (k == 2) p_reset = 1'b0;
          check_val("rst_quiet", 83'({lk.mem_write, lk.lookup_ack, lk.check_age}), '0);
        end
        @(negedge pclk);
        check_val("post_rst_idle", 83'({lk.mem_write, lk.lookup_ack, lk.add_check_active}), '0);
        return;
      end

      if (lk.mem_write) begin
        wr_n++;
        wr_c = n;
        wr_a = lk.mem_addr;
        wr_d = lk.mem_write_data;
        phys_mem[lk.mem_addr] = lk.mem_write_data;
      end else if (lk.mem_write_data != '0) begin
        bad_wd++;
      end
      if (lk.check_age) begin
        ca_n++;
        if (ca_c < 0) ca_c = n;
      end
      if (lk.add_check_active) begin
        aca_n++;
        if (aca_first < 0) aca_first = n;
      end
      if (n == 1) check_val("rd_addr", 83'(lk.mem_addr), 83'(idx));
      if (lk.lookup_ack) begin
        ack_c     = n;
        seen_hit  = lk.lookup_hit;
        seen_aged = lk.lookup_aged;
        seen_err  = lk.lookup_err;
        seen_dst  = lk.lookup_dst_port;
        seen_last = lk.last_accessed;
      end

      // drive this cycle's inputs
      lk.lookup_req = keep_req && lk.lookup_ack;
      lk.mem_read_data = phys_mem[rd_a];
      if (!lk.mem_write) rd_a = lk.mem_addr;
      ct[n] = $urandom;
      lk.curr_time = ct[n];
      lk.age_check_active = (n <= busy);
      lk.age_confirmed = (dly != 0) && (ca_c > 0) && (n == ca_c + dly);
      lk.age_ok = lk.age_confirmed ? ok : 1'($urandom_range(0, 1));
    end
    lk.age_confirmed = 1'b0;

    exp_hit = 1'b0; exp_aged = 1'b0; exp_err = 1'b0; exp_dst = '0; req_c = -1;
    if (!tag) begin
      exp_ack = 4;
      exp_wr  = 3;
      exp_wd  = {1'b1, ct[2], port, addr};
      exp_aca = 0;
    end else begin
      req_c = (busy + 2 > 4) ? busy + 2 : 4;
      if (dly == 0) begin
        exp_ack = req_c + int'(AGE_TIMEOUT) + 1;
        exp_wr  = -1;
        exp_aca = int'(AGE_TIMEOUT) + 1;
        exp_err = 1'b1;
      end else begin
        exp_wr   = req_c + dly + 1;
        exp_ack  = exp_wr + 1;
        exp_wd   = {1'b1, ct[req_c + dly], port, addr};
        exp_aca  = dly + 1;
        exp_hit  = ok;
        exp_aged = !ok;
        exp_dst  = ok ? ent[49:48] : 2'b00;
      end
    end

    check_val("ack_cycle", 83'(ack_c), 83'(exp_ack));
    check_val("write_count", 83'(wr_n), 83'((exp_wr > 0) ? 1 : 0));
    if (exp_wr > 0) begin
      check_val("write_cycle", 83'(wr_c), 83'(exp_wr));
      check_val("write_addr", 83'(wr_a), 83'(idx));
      check_val("write_data", wr_d, exp_wd);
      ref_mem[idx] = exp_wd;
    end
    check_val("wdata_idle_zero", 83'(bad_wd), '0);
    check_val("check_age_count", 83'(ca_n), 83'(tag ? 1 : 0));
    check_val("owner_cycles", 83'(aca_n), 83'(exp_aca));
    if (tag) begin
      check_val("check_age_cycle", 83'(ca_c), 83'(req_c));
      check_val("owner_first", 83'(aca_first), 83'(req_c));
      check_val("last_accessed", 83'(seen_last), 83'(ent[81:50]));
    end
    check_val("hit", 83'(seen_hit), 83'(exp_hit));
    check_val("aged", 83'(seen_aged), 83'(exp_aged));
    check_val("err", 83'(seen_err), 83'(exp_err));
    check_val("dst_port", 83'(seen_dst), 83'(exp_dst));
    obs_ack  = ack_c;
    obs_wr_a = wr_a;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [47:0] pool [8];
    logic [63:0] r64;
    logic [47:0] a;
    bit          kr;
    int          dly;

    p_reset = 1'b1;
    lk.lookup_req = 1'b0;
    lk.lookup_addr = '0;
    lk.lookup_port = '0;
    lk.curr_time = '0;
    lk.mem_read_data = '0;
    lk.age_check_active = 1'b0;
    lk.age_confirmed = 1'b0;
    lk.age_ok = 1'b0;
    obs_ack = 0;
    obs_wr_a = '0;
    for (int i = 0; i < 256; i++) begin
      phys_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    repeat (3) @(negedge pclk);
    check_val("reset_outs", outs_vec(), '0);
    check_val("reset_wdata", lk.mem_write_data, '0);
    p_reset = 1'b0;

    // learn into an empty table
    run_lookup(48'h0102_0304_0506, 2'd2, 0, 2, 1'b1, 1'b0, 0);
    check_val("learn_index", 83'(obs_wr_a), 83'(8'h07));
    check_val("learn_latency", 83'(obs_ack), 83'(4));

    // same address again: in-date hit
    run_lookup(48'h0102_0304_0506, 2'd2, 0, 2, 1'b1, 1'b0, 0);
    check_val("hit_latency", 83'(obs_ack), 83'(8));

    // preloaded entry reported out of date
    phys_mem[1] = {1'b1, 32'h0000_1234, 2'd1, 48'h0000_0000_0001};
    ref_mem[1]  = phys_mem[1];
    run_lookup(48'h0000_0000_0001, 2'd3, 0, 3, 1'b0, 1'b0, 0);

    // age checker busy for 20 cycles
    run_lookup(48'h0102_0304_0506, 2'd1, 20, 3, 1'b1, 1'b0, 0);

    // checker never confirms
    run_lookup(48'h0102_0304_0506, 2'd0, 0, 0, 1'b0, 1'b0, 0);
    check_val("timeout_latency", 83'(obs_ack), 83'(4 + AGE_TIMEOUT + 1));

    // reset while waiting for the checker
    run_lookup(48'h0102_0304_0506, 2'd0, 0, 0, 1'b0, 1'b0, 7);

    // request held across ack, then back-to-back lookup
    run_lookup(48'h0102_0304_0506, 2'd1, 0, 1, 1'b1, 1'b1, 0);
    run_lookup(48'h0000_0000_0001, 2'd0, 0, 16, 1'b1, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      r64 = {$urandom, $urandom};
      pool[i] = r64[47:0];
    end
    for (int t = 0; t < 40; t++) begin
      r64 = {$urandom, $urandom};
      a   = ($urandom_range(0, 4) == 0) ? r64[47:0] : pool[$urandom_range(0, 7)];
      dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 16));
      kr  = 1'($urandom_range(0, 1));
      run_lookup(a, 2'($urandom_range(0, 3)), int'($urandom_range(0, 6)), dly,
                 1'($urandom_range(0, 1)), kr, 0);
      if (!kr) repeat ($urandom_range(0, 2)) @(negedge pclk);
    end

    @(negedge pclk);
    lk.lookup_req = 1'b0;
    repeat (2) @(negedge pclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alut_lookup_engine.md
# alut_lookup_engine

Address-lookup initiator for the ALUT. For each learn/lookup request it hashes a 48-bit MAC address to an 8-bit table index and reads the 83-bit entry. On a tag hit it requests an age check from the age checker through the `check_age` / `add_check_active` / `age_confirmed` / `age_ok` handshake, then refreshes, relearns or reports an error. It drives the ALUT memory port dedicated to address checking and sits between the APB-side switch logic and the age checker.

## Interface
- AGE_TIMEOUT, 16: maximum cycles to wait for `age_confirmed` after issuing `check_age`.
- pclk  in  1  clock
- p_reset  in  1  reset. One clock; reset is asynchronous and active-high.
- lookup_req  in  1  request; level, sampled only in IDLE
- lookup_addr  in  48  MAC address to look up/learn
- lookup_port  in  2  source port of the request
- curr_time  in  32  current time from the age checker
- mem_read_data  in  83  entry read data; valid one cycle after address presented with `mem_write`=0
- age_check_active  in  1  age checker busy (non-idle)
- age_confirmed  in  1  age checker result valid
- age_ok  in  1  age checker result: 1 = in date
- mem_addr  out  8  memory address
- mem_write  out  1  memory write strobe
- mem_write_data  out  83  memory write data
- check_age  out  1  one-cycle age-check request
- last_accessed  out  32  timestamp under check
- add_check_active  out  1  high while this block owns the age checker
- lookup_ack  out  1  one-cycle completion pulse
- lookup_hit  out  1  valid, in-date entry found
- lookup_aged  out  1  entry found but out of date (relearned)
- lookup_err  out  1  age check timed out
- lookup_dst_port  out  2  stored port on hit, else 0

## Operation
- Entry format: [82] valid, [81:50] last-accessed time, [49:48] port, [47:0] address.
- Index: XOR of the six bytes of `lookup_addr`.
- Accept: in IDLE with `lookup_req`=1, latch addr, port and index; clear `lookup_hit`, `lookup_aged`, `lookup_err` and `lookup_dst_port`.
- States: IDLE, RD, CMP, ARB, REQ, WAIT, WR, DONE.
- IDLE→RD on accept.
- RD: `mem_addr`=index, `mem_write`=0; →CMP.
- CMP: `mem_read_data` is valid.
  - Valid entry and [47:0]==addr: →ARB, and latch [81:50] into `last_accessed` and [49:48] as stored port.
  - Otherwise (miss): →WR with learn data {1, curr_time, req port, addr}.
- ARB: wait while `age_check_active`=1 (no limit); →REQ when it is 0.
- REQ: `check_age`=1 for exactly one cycle; `add_check_active`=1; clear the timeout counter; →WAIT.
- WAIT: `add_check_active`=1; the counter increments each cycle.
  - `age_confirmed`=1 and `age_ok`=1: hit. Set `lookup_hit`=1 and `lookup_dst_port`=stored port. →WR with refresh data {1, curr_time, req port, addr}.
  - `age_confirmed`=1 and `age_ok`=0: set `lookup_aged`=1. →WR with learn data.
  - Counter == AGE_TIMEOUT-1 with no confirm: set `lookup_err`=1; →DONE with no write.
  - `age_confirmed` has priority over timeout in the same cycle.
- WR: `mem_write`=1 for one cycle, `mem_addr`=index, `mem_write_data`=data; →DONE.
- DONE: `lookup_ack`=1; →IDLE.
- Result outputs hold until the next accept.
- `mem_write_data` is 0 whenever `mem_write`=0.
- `add_check_active` is 0 outside REQ and WAIT.
- `check_age` is never reasserted while in WAIT. A lost request (the age checker took a command in the same cycle) is covered by the timeout.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0.
- A `p_reset` assertion mid-operation aborts immediately: no ack and no write, even if in WR.
- Hit, checker free, with accept edge at T0:
  - RD in T1, CMP in T2, ARB in T3, REQ (`check_age`) in T4.
  - Checker enters its check state at T5; `age_confirmed` is high in T6.
  - WR in T7; `lookup_ack` in T8.
  - Request-to-ack latency is 8 cycles.
- Miss: RD T1, CMP T2, WR T3, ack T4 (4 cycles).
- Timeout: ack AGE_TIMEOUT+1 cycles after REQ.
- `lookup_req` held high after ack starts a new lookup on the cycle after DONE.
- `curr_time` is sampled in the cycle the write data is selected: CMP for a miss, WAIT for a hit or aged entry.

## Test plan
- Empty table, addr 48'h0102_0304_0506, port 2 → write at index 8'h07 with data {1, curr_time, 2'd2, addr}; ack 4 cycles after accept; `lookup_hit`=0, `lookup_aged`=0.
- Repeat the same addr, checker model returns `age_ok`=1 two cycles after `check_age` → one `check_age` pulse; `last_accessed`=stored time; `lookup_hit`=1; `lookup_dst_port`=2; timestamp refreshed; ack 8 cycles after accept.
- Entry at index 8'h01 holds addr 48'h0000_0000_0001 and the checker returns `age_ok`=0 → `lookup_aged`=1, `lookup_hit`=0; entry overwritten with the new timestamp.
- Hold `age_check_active`=1 for 20 cycles on a hit → `check_age` is issued only after it drops; `add_check_active` stays 0 while waiting.
- Checker never confirms → `lookup_err`=1; no `mem_write`; ack 17 cycles after REQ with AGE_TIMEOUT=16.
- Assert `p_reset` during WAIT → all outputs 0 on the next edge; no ack; no write.
